// File: rtl/node_integrator.sv
// rtl/node_integrator.sv - per-node force accumulation and semi-implicit Euler step
// Beats accumulate in IDLE; force_last starts a one-node-per-cycle integration sweep.
module node_integrator #(
  parameter int NUM_NODES     = 10,
  parameter int POSITION_SIZE = 8,
  parameter int VELOCITY_SIZE = 8,
  parameter int FORCE_SIZE    = 8,
  parameter int ACC_SIZE      = 12,
  parameter int DT_SHIFT      = 2,
  parameter int MASS_SHIFT    = 0,
  parameter int FLOOR_Y       = -(2 ** (POSITION_SIZE - 1)),
  localparam int IW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            force_valid,
  output logic                            force_ready,
  input  logic                            force_last,
  input  logic [IW-1:0]                   force_node_a,
  input  logic [IW-1:0]                   force_node_b,
  input  logic signed [FORCE_SIZE-1:0]    force_x,
  input  logic signed [FORCE_SIZE-1:0]    force_y,
  input  logic signed [FORCE_SIZE-1:0]    gravity_y,
  input  logic                            init_valid,
  input  logic [IW-1:0]                   init_node,
  input  logic signed [POSITION_SIZE-1:0] init_x,
  input  logic signed [POSITION_SIZE-1:0] init_y,
  output logic signed [POSITION_SIZE-1:0] pos_x [NUM_NODES],
  output logic signed [POSITION_SIZE-1:0] pos_y [NUM_NODES],
  output logic signed [VELOCITY_SIZE-1:0] vel_x [NUM_NODES],
  output logic signed [VELOCITY_SIZE-1:0] vel_y [NUM_NODES],
  output logic                            busy,
  output logic                            output_valid
);

  localparam int MW1 = (ACC_SIZE > FORCE_SIZE) ? ACC_SIZE : FORCE_SIZE;
  localparam int MW2 = (MW1 > VELOCITY_SIZE) ? MW1 : VELOCITY_SIZE;
  localparam int MW3 = (MW2 > POSITION_SIZE) ? MW2 : POSITION_SIZE;
  localparam int WW  = MW3 + 2;
  localparam logic signed [WW-1:0] FLOOR_W = WW'(FLOOR_Y);

  typedef enum logic [1:0] {IDLE, INTEGRATE, DONE} state_t;

  state_t state;
  logic [IW-1:0] idx;

  logic signed [ACC_SIZE-1:0] acc_x     [NUM_NODES];
  logic signed [ACC_SIZE-1:0] acc_y     [NUM_NODES];
  logic signed [ACC_SIZE-1:0] acc_x_nxt [NUM_NODES];
  logic signed [ACC_SIZE-1:0] acc_y_nxt [NUM_NODES];

  logic a_ok, b_ok, distinct, accept, init_ok;
  logic signed [VELOCITY_SIZE-1:0] vx_new, vy_new;
  logic signed [POSITION_SIZE-1:0] px_new, py_new;

  function automatic logic signed [WW-1:0] sat(input logic signed [WW-1:0] v, input int w);
    logic signed [WW-1:0] lo, hi;
    lo = {WW{1'b1}} << (w - 1);
    hi = ~lo;
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

  assign force_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign accept      = force_valid && force_ready;
  assign a_ok        = ({1'b0, force_node_a} < (IW+1)'(NUM_NODES));
  assign b_ok        = ({1'b0, force_node_b} < (IW+1)'(NUM_NODES));
  assign init_ok     = ({1'b0, init_node} < (IW+1)'(NUM_NODES));
  // A self-loop beat cancels exactly, so it is skipped rather than saturated twice.
  assign distinct    = (force_node_a != force_node_b);

  always_comb begin : beat_comb
    logic signed [WW-1:0] fx_w, fy_w, dx, dy, sx, sy;
    fx_w = force_x;
    fy_w = force_y;
    for (int n = 0; n < NUM_NODES; n++) begin
      dx = '0;
      dy = '0;
      if (distinct && a_ok && force_node_a == IW'(n)) begin
        dx = -fx_w;
        dy = -fy_w;
      end
      if (distinct && b_ok && force_node_b == IW'(n)) begin
        dx = fx_w;
        dy = fy_w;
      end
      sx = acc_x[n];
      sy = acc_y[n];
      acc_x_nxt[n] = ACC_SIZE'(sat(sx + dx, ACC_SIZE));
      acc_y_nxt[n] = ACC_SIZE'(sat(sy + dy, ACC_SIZE));
    end
  end

  always_comb begin : step_comb
    logic signed [WW-1:0] ax, ay, t, g, vx, vy, px, py;
    t  = acc_x[idx];
    ax = sat(t, ACC_SIZE) >>> MASS_SHIFT;
    t  = acc_y[idx];
    g  = gravity_y;
    ay = sat(t + g, ACC_SIZE) >>> MASS_SHIFT;
    t  = vel_x[idx];
    vx = sat(t + (ax >>> DT_SHIFT), VELOCITY_SIZE);
    t  = vel_y[idx];
    vy = sat(t + (ay >>> DT_SHIFT), VELOCITY_SIZE);
    // Position uses the freshly updated velocity (semi-implicit Euler).
    t  = pos_x[idx];
    px = sat(t + (vx >>> DT_SHIFT), POSITION_SIZE);
    t  = pos_y[idx];
    py = sat(t + (vy >>> DT_SHIFT), POSITION_SIZE);
    if (py < FLOOR_W) begin
      py = FLOOR_W;
      vy = '0;
    end
    vx_new = VELOCITY_SIZE'(vx);
    vy_new = VELOCITY_SIZE'(vy);
    px_new = POSITION_SIZE'(px);
    py_new = POSITION_SIZE'(py);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state        <= IDLE;
      idx          <= '0;
      output_valid <= 1'b0;
      for (int n = 0; n < NUM_NODES; n++) begin
        acc_x[n] <= '0;
        acc_y[n] <= '0;
        pos_x[n] <= '0;
        pos_y[n] <= '0;
        vel_x[n] <= '0;
        vel_y[n] <= '0;
      end
    end else begin
      output_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            acc_x <= acc_x_nxt;
            acc_y <= acc_y_nxt;
            if (force_last) begin
              state <= INTEGRATE;
              idx   <= '0;
            end
          end
          if (init_valid && init_ok) begin
            pos_x[init_node] <= init_x;
            pos_y[init_node] <= init_y;
            vel_x[init_node] <= '0;
            vel_y[init_node] <= '0;
          end
        end
        INTEGRATE: begin
          vel_x[idx] <= vx_new;
          vel_y[idx] <= vy_new;
          pos_x[idx] <= px_new;
          pos_y[idx] <= py_new;
          acc_x[idx] <= '0;
          acc_y[idx] <= '0;
          if (idx == IW'(NUM_NODES - 1)) begin
            state        <= DONE;
            output_valid <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_node_integrator.sv
// tb/tb_node_integrator.sv - scoreboard bench for node_integrator with a frame-level model
`timescale 1ns/1ps
module tb_node_integrator;
  localparam int N     = 10;
  localparam int PS    = 8;
  localparam int VS    = 8;
  localparam int AS    = 12;
  localparam int DT    = 2;
  localparam int MS    = 0;
  localparam int FLOOR = -100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic force_valid = 1'b0, force_last = 1'b0, init_valid = 1'b0;
  logic [3:0] force_node_a = '0, force_node_b = '0, init_node = '0;
  logic signed [7:0] force_x = '0, force_y = '0, gravity_y = '0, init_x = '0, init_y = '0;
  logic force_ready, busy, output_valid;
  logic signed [7:0] pos_x [N];
  logic signed [7:0] pos_y [N];
  logic signed [7:0] vel_x [N];
  logic signed [7:0] vel_y [N];

  node_integrator #(.FLOOR_Y(FLOOR)) dut (
    .clk_in(clk), .rst_in(rst),
    .force_valid(force_valid), .force_ready(force_ready), .force_last(force_last),
    .force_node_a(force_node_a), .force_node_b(force_node_b),
    .force_x(force_x), .force_y(force_y), .gravity_y(gravity_y),
    .init_valid(init_valid), .init_node(init_node), .init_x(init_x), .init_y(init_y),
    .pos_x(pos_x), .pos_y(pos_y), .vel_x(vel_x), .vel_y(vel_y),
    .busy(busy), .output_valid(output_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int m_px[N], m_py[N], m_vx[N], m_vy[N], m_ax[N], m_ay[N];
  int exp_cyc[$];
  int exp_val[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int hi, lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_px[i] = 0; m_py[i] = 0; m_vx[i] = 0; m_vy[i] = 0; m_ax[i] = 0; m_ay[i] = 0;
    end
  endtask

  task automatic model_beat(input int a, input int b, input int fx, input int fy);
    if (a != b) begin
      if (a < N) begin
        m_ax[a] = sat(m_ax[a] - fx, AS);
        m_ay[a] = sat(m_ay[a] - fy, AS);
      end
      if (b < N) begin
        m_ax[b] = sat(m_ax[b] + fx, AS);
        m_ay[b] = sat(m_ay[b] + fy, AS);
      end
    end
  endtask

  task automatic model_frame(input int g, input int done_cyc);
    int ax, ay;
    for (int i = 0; i < N; i++) begin
      ax = sat(m_ax[i], AS) >>> MS;
      ay = sat(m_ay[i] + g, AS) >>> MS;
      m_vx[i] = sat(m_vx[i] + (ax >>> DT), VS);
      m_vy[i] = sat(m_vy[i] + (ay >>> DT), VS);
      m_px[i] = sat(m_px[i] + (m_vx[i] >>> DT), PS);
      m_py[i] = sat(m_py[i] + (m_vy[i] >>> DT), PS);
      if (m_py[i] < FLOOR) begin
        m_py[i] = FLOOR;
        m_vy[i] = 0;
      end
      m_ax[i] = 0;
      m_ay[i] = 0;
      exp_val.push_back(m_px[i]);
      exp_val.push_back(m_py[i]);
      exp_val.push_back(m_vx[i]);
      exp_val.push_back(m_vy[i]);
    end
    exp_cyc.push_back(done_cyc);
  endtask

  // Monitor: pops one expected frame per output_valid pulse.
  initial begin
    int e;
    bit chk_ready;
    chk_ready = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk_ready = 0;
      end else begin
        if (chk_ready) begin
          check("ready after done", int'(force_ready), 1);
          check("busy after done", int'(busy), 0);
          chk_ready = 0;
        end
        if (output_valid) begin
          if (exp_cyc.size() == 0) begin
            check("unexpected output_valid", 1, 0);
          end else begin
            e = exp_cyc.pop_front();
            check("output_valid cycle", cyc, e);
            check("busy during done", int'(busy), 1);
            check("ready during done", int'(force_ready), 0);
            for (int i = 0; i < N; i++) begin
              check($sformatf("pos_x[%0d]", i), int'(pos_x[i]), exp_val.pop_front());
              check($sformatf("pos_y[%0d]", i), int'(pos_y[i]), exp_val.pop_front());
              check($sformatf("vel_x[%0d]", i), int'(vel_x[i]), exp_val.pop_front());
              check($sformatf("vel_y[%0d]", i), int'(vel_y[i]), exp_val.pop_front());
            end
            chk_ready = 1;
          end
        end else if (exp_cyc.size() > 0 && cyc > exp_cyc[0]) begin
          check("output_valid timeout", 0, 1);
          e = exp_cyc.pop_front();
          for (int i = 0; i < 4 * N; i++) e = exp_val.pop_front();
        end
      end
    end
  end

  task automatic do_init(input int node, input int x, input int y, input bit applies);
    init_valid = 1'b1;
    init_node  = 4'(node);
    init_x     = 8'(x);
    init_y     = 8'(y);
    if (applies && node < N) begin
      m_px[node] = x; m_py[node] = y; m_vx[node] = 0; m_vy[node] = 0;
    end
    @(negedge clk);
    init_valid = 1'b0;
  endtask

  task automatic beat(input int a, input int b, input int fx, input int fy,
                      input bit last, output int acc_cyc);
    int w;
    force_valid  = 1'b1;
    force_last   = last;
    force_node_a = 4'(a);
    force_node_b = 4'(b);
    force_x      = 8'(fx);
    force_y      = 8'(fy);
    w = 0;
    while (!force_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!force_ready) begin
      check("beat accept timeout", 0, 1);
      acc_cyc = -1;
    end else begin
      acc_cyc = cyc + 1;
      model_beat(a, b, fx, fy);
      if (last) model_frame(int'(gravity_y), acc_cyc + N);
    end
    @(negedge clk);
    force_valid = 1'b0;
    force_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (exp_cyc.size() > 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
  endtask

  task automatic basic_frame(input string tag);
    int e;
    gravity_y = '0;
    do_init(0, 10, 20, 1);
    do_init(1, 0, 0, 1);
    beat(0, 1, 8, -4, 1, e);
    wait_idle();
    check({tag, " n1 vx"}, int'(vel_x[1]), 2);
    check({tag, " n1 vy"}, int'(vel_y[1]), -1);
    check({tag, " n1 px"}, int'(pos_x[1]), 0);
    check({tag, " n1 py"}, int'(pos_y[1]), -1);
    check({tag, " n0 vx"}, int'(vel_x[0]), -2);
    check({tag, " n0 vy"}, int'(vel_y[0]), 1);
    check({tag, " n0 px"}, int'(pos_x[0]), 9);
    check({tag, " n0 py"}, int'(pos_y[0]), 20);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " force_ready"}, int'(force_ready), 1);
    check({tag, " busy"}, int'(busy), 0);
    check({tag, " output_valid"}, int'(output_valid), 0);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s pos_x[%0d]", tag, i), int'(pos_x[i]), 0);
      check($sformatf("%s pos_y[%0d]", tag, i), int'(pos_y[i]), 0);
      check($sformatf("%s vel_x[%0d]", tag, i), int'(vel_x[i]), 0);
      check($sformatf("%s vel_y[%0d]", tag, i), int'(vel_y[i]), 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, e1, e2, nb, g;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);

    basic_frame("basic");

    // Floor clamp.
    gravity_y = 8'(-16);
    do_init(0, 0, -99, 1);
    beat(0, 0, 0, 0, 1, e);
    wait_idle();
    check("floor f1 vy", int'(vel_y[0]), -4);
    check("floor f1 py", int'(pos_y[0]), -100);
    beat(0, 0, 0, 0, 1, e);
    wait_idle();
    check("floor f2 vy", int'(vel_y[0]), 0);
    check("floor f2 py", int'(pos_y[0]), -100);

    // Saturation of accumulator, velocity and position.
    gravity_y = '0;
    do_init(2, 0, 0, 1);
    do_init(4, 0, 0, 1);
    for (int j = 0; j < 20; j++) beat(4, 2, 127, 0, j == 19, e);
    wait_idle();
    check("sat n2 vx", int'(vel_x[2]), 127);
    check("sat n2 px", int'(pos_x[2]), 31);
    check("sat n4 vx", int'(vel_x[4]), -128);
    check("sat n4 px", int'(pos_x[4]), -32);

    // Self-loop and out-of-range halves.
    do_init(3, 5, 5, 1);
    do_init(6, 0, 0, 1);
    beat(3, 3, 50, 50, 0, e);
    beat(6, 12, 40, 0, 1, e);
    wait_idle();
    check("selfloop n3 px", int'(pos_x[3]), 5);
    check("selfloop n3 py", int'(pos_y[3]), 5);
    check("selfloop n3 vx", int'(vel_x[3]), 0);
    check("oor n6 vx", int'(vel_x[6]), -10);
    check("oor n6 px", int'(pos_x[6]), -3);

    // Held beat during INTEGRATE, init ignored while busy.
    beat(1, 2, 20, 20, 1, e1);
    do_init(7, 99, 99, 0);
    beat(2, 3, -20, 10, 1, e2);
    check("held beat accept cycle", e2, e1 + N + 2);
    wait_idle();

    // Reset in the middle of a sweep.
    beat(0, 1, 8, -4, 1, e);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    exp_cyc.delete();
    exp_val.delete();
    model_reset();
    #1;
    check_reset_state("midreset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    basic_frame("after reset");

    // Randomized frames.
    for (int f = 0; f < 8; f++) begin
      g = int'($urandom_range(16)) - 8;
      gravity_y = 8'(g);
      for (int k = 0; k < 2; k++)
        do_init(int'($urandom_range(11)), int'($urandom_range(120)) - 60,
                int'($urandom_range(120)) - 60, 1);
      nb = int'($urandom_range(6, 1));
      for (int j = 0; j < nb; j++) begin
        beat(int'($urandom_range(11)), int'($urandom_range(11)),
             int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
             j == nb - 1, e);
        repeat ($urandom_range(2)) @(negedge clk);
      end
      wait_idle();
    end

    wait_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/node_integrator.md
# node_integrator

Time-step integrator for the soft-body car. It consumes the per-spring force stream produced by the spring stage, accumulates a net force per node, adds gravity, and applies a semi-implicit Euler update to every node's velocity and position. The updated position and velocity arrays are fed back to the spring stage for the next physics frame.

## Interface
Parameters:
- NUM_NODES, 10, number of simulated nodes
- POSITION_SIZE, 8, signed position width
- VELOCITY_SIZE, 8, signed velocity width
- FORCE_SIZE, 8, signed force-beat and gravity width
- ACC_SIZE, 12, signed per-node force accumulator width
- DT_SHIFT, 2, time step as a right shift (dt = 2^-DT_SHIFT)
- MASS_SHIFT, 0, mass as a right shift (a = F >>> MASS_SHIFT)
- FLOOR_Y, -(2^(POSITION_SIZE-1)), ground height; the default disables the floor

Ports:
- clk_in  in  1  clock
- rst_in  in  1  reset, asynchronous, active-high
- force_valid  in  1  force beat present
- force_ready  out  1  high iff state is IDLE
- force_last  in  1  final beat of the frame; qualified by force_valid
- force_node_a  in  $clog2(NUM_NODES)  receives -F
- force_node_b  in  $clog2(NUM_NODES)  receives +F
- force_x, force_y  in  FORCE_SIZE signed  spring force on node_b
- gravity_y  in  FORCE_SIZE signed  added to every node's y force each frame
- init_valid  in  1  position load (IDLE only)
- init_node  in  $clog2(NUM_NODES)  node to load
- init_x, init_y  in  POSITION_SIZE signed  loaded position
- pos_x, pos_y  out  [NUM_NODES] x POSITION_SIZE signed  node positions
- vel_x, vel_y  out  [NUM_NODES] x VELOCITY_SIZE signed  node velocities
- busy  out  1  high in INTEGRATE and DONE
- output_valid  out  1  one-cycle pulse: frame complete

## Operation
- States: IDLE, INTEGRATE, DONE. Reset enters IDLE.
- IDLE:
  - Each accepted beat (force_valid & force_ready) saturating-adds -F to node_a's accumulators and +F to node_b's.
  - If node_a == node_b, the net change is zero.
  - A node index >= NUM_NODES drops that half of the beat.
- force_last on an accepted beat: that beat is accumulated, then IDLE -> INTEGRATE.
- init_valid in IDLE: pos[init_node] <= (init_x, init_y) and vel[init_node] <= 0. init_valid is ignored outside IDLE and for out-of-range nodes. init and a force beat in the same cycle both take effect.
- INTEGRATE: one node per cycle, index i = 0..NUM_NODES-1.
  - ax = sat_ACC(acc_x) >>> MASS_SHIFT
  - ay = sat_ACC(acc_y + gravity_y) >>> MASS_SHIFT
  - vx' = sat_V(vx + (ax >>> DT_SHIFT)); vy' likewise
  - px' = sat_P(px + (vx' >>> DT_SHIFT)); py' likewise
  - If py' < FLOOR_Y: py' = FLOOR_Y and vy' = 0.
  - acc[i] is cleared in the same cycle.
  - After i = NUM_NODES-1 -> DONE.
- DONE: output_valid = 1 for one cycle, then -> IDLE.
- Arithmetic rules:
  - All arithmetic is signed.
  - `>>>` is arithmetic (floor toward -inf).
  - sat_W clamps to [-(2^(W-1)), 2^(W-1)-1].
  - Intermediate sums are computed at full width before saturation.

## Timing
- Reset values: all pos, vel and accumulators 0; state IDLE; output_valid 0; busy 0; force_ready 1 (IDLE).
- Accumulation takes effect at the clock edge after acceptance.
- force_last accepted at edge t:
  - INTEGRATE during cycles t+1 .. t+NUM_NODES
  - DONE (output_valid=1) in cycle t+NUM_NODES+1
  - IDLE and force_ready=1 in cycle t+NUM_NODES+2
- pos/vel for node i update at the end of its INTEGRATE cycle. All outputs are stable and final while output_valid is high and throughout IDLE.
- force_valid while force_ready=0 is not accepted; the sender holds the beat.
- rst_in asserted mid-INTEGRATE: everything returns to reset values immediately, and the partial frame is discarded.

## Test plan
- Basic frame: init node0=(10,20), node1=(0,0), gravity 0; beat a=0, b=1, F=(8,-4), last. Required: node1 vel=(2,-1), pos=(0,-1); node0 vel=(-2,1), pos=(9,20). output_valid exactly at cycle t+11.
- Floor: FLOOR_Y=0, gravity_y=-16, node0 at y=1. Frame 1 -> vy=-4, y=0. Frame 2 -> y clamped to 0, vy=0.
- Saturation: 20 beats of fx=127 to node2 (b) -> acc_x clamps to 2047, vx=127, px=31. Node a of those beats clamps to vx=-128, px=-32.
- Self-loop and out-of-range: beat a=b=3, F=(50,50) -> node3 unchanged. Beat b=12 -> only node_a is affected.
- Handshake: force_valid held during INTEGRATE -> not accepted until force_ready returns. init_valid during INTEGRATE is ignored.
- Reset mid-INTEGRATE at node 5 -> all outputs 0, IDLE, force_ready=1; the next frame behaves as in the basic-frame scenario.
